// File: rtl/ws_pkg.sv
// Shared types and bit maps for the 6502 wait-state generator.
package ws_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_ROM  = 2'd1,
        REG_IO   = 2'd2,
        REG_RAM  = 2'd3
    } region_t;

    localparam int PHI2_BIT = 0;
    localparam int ROM_BIT  = 1;
    localparam int RAM_BIT  = 2;
    localparam int IO_BIT   = 3;

    localparam int CS_ROM = 0;
    localparam int CS_RAM = 1;
    localparam int CS_IO  = 2;

    localparam int ROM_W_LSB = 0;
    localparam int ROM_W_MSB = 2;
    localparam int IO_W_LSB  = 3;
    localparam int IO_W_MSB  = 5;
    localparam int RAM_W_LSB = 6;
    localparam int RAM_W_MSB = 7;

    localparam logic [7:0] UO_RESET = 8'h01;

    function automatic region_t pick_region(input logic [2:0] cs_n);
        region_t r;
        r = REG_NONE;
        if (!cs_n[CS_ROM])
            r = REG_ROM;
        else if (!cs_n[CS_IO])
            r = REG_IO;
        else if (!cs_n[CS_RAM])
            r = REG_RAM;
        return r;
    endfunction

endpackage

// File: rtl/tt_um_6502_wait_state_phi2_sync.sv
// Aligned synchroniser for PHI2 plus a bus vector, with PHI2 fall detect.
module phi2_sync #(
    parameter int STAGES = 2,
    parameter int W      = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         phi2,
    input  logic [W-1:0] bus_in,
    output logic [W-1:0] bus_out,
    output logic         cyc_end
);

    logic [W:0] chain [STAGES];
    logic       phi2_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++)
                chain[i] <= '1;
            phi2_prev <= 1'b1;
        end else begin
            chain[0] <= {bus_in, phi2};
            for (int i = 1; i < STAGES; i++)
                chain[i] <= chain[i-1];
            phi2_prev <= chain[STAGES-1][0];
        end
    end

    assign bus_out = chain[STAGES-1][W:1];
    assign cyc_end = phi2_prev & ~chain[STAGES-1][0];

endmodule

// File: rtl/tt_um_6502_wait_state.sv
// Drives 6502 RDY low for a programmable number of PHI2 cycles
// on slow regions, with a sticky conflict flag and stall counter.
module tt_um_6502_wait_state
    import ws_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STALL_CNT_W = 5
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [2:0] cs_n_s;
    logic       cyc_end;

    phi2_sync #(
        .STAGES(SYNC_STAGES),
        .W     (3)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .phi2   (ui_in[PHI2_BIT]),
        .bus_in (ui_in[IO_BIT:ROM_BIT]),
        .bus_out(cs_n_s),
        .cyc_end(cyc_end)
    );

    state_t                 state;
    logic [2:0]             wcnt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   rdy_q;
    logic                   busy_q;
    logic                   conf_q;

    region_t    region;
    logic [2:0] nwait;
    logic       multi;

    always_comb begin
        region = pick_region(cs_n_s);
        nwait  = 3'd0;
        unique case (region)
            REG_ROM: nwait = uio_in[ROM_W_MSB:ROM_W_LSB];
            REG_IO:  nwait = uio_in[IO_W_MSB:IO_W_LSB];
            REG_RAM: nwait = {1'b0, uio_in[RAM_W_MSB:RAM_W_LSB]};
            default: nwait = 3'd0;
        endcase
    end

    assign multi = (~cs_n_s[0] & ~cs_n_s[1])
                 | (~cs_n_s[0] & ~cs_n_s[2])
                 | (~cs_n_s[1] & ~cs_n_s[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= 3'd0;
            stall_cnt <= '0;
            rdy_q     <= UO_RESET[0];
            busy_q    <= UO_RESET[1];
            conf_q    <= UO_RESET[2];
        end else if (cyc_end) begin
            if (multi)
                conf_q <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (nwait != 3'd0) begin
                        wcnt   <= nwait;
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wcnt <= wcnt - 3'd1;
                    if (stall_cnt != '1)
                        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
                    if (wcnt == 3'd1) begin
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_RELEASE;
                    end
                end
                // CS is still asserted while the CPU finishes the access.
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    assign uo_out  = {stall_cnt, conf_q, busy_q, rdy_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused;
    assign unused = &{ena, ui_in[7:4], 1'b0};

endmodule

// File: tb/tb_tt_um_6502_wait_state.sv
// Directed bench for the wait-state generator.
module tb_tt_um_6502_wait_state;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    tt_um_6502_wait_state dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one PHI2 cycle; csn = {IO, RAM, ROM}, ends 8 clocks past the fall
    task automatic bus_cycle(input logic [2:0] csn);
        ui_in[3:1] = csn;
        ui_in[0]   = 1'b1;
        repeat (8) @(negedge clk);
        ui_in[0]   = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] cfg);
        @(negedge clk);
        rst_n  = 1'b0;
        ui_in  = 8'h0F;
        uio_in = cfg;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    localparam logic [2:0] NONE  = 3'b111;
    localparam logic [2:0] ROM   = 3'b110;
    localparam logic [2:0] RAM   = 3'b101;
    localparam logic [2:0] IO    = 3'b011;
    localparam logic [2:0] ROMIO = 3'b010;

    initial begin
        ui_in  = 8'h0F;
        uio_in = 8'hFF;
        ena    = 1'b1;
        rst_n  = 1'b1;

        do_reset(8'hFF);
        chk("reset_uo", uo_out, 8'h01);
        chk("uio_oe", uio_oe, 8'h00);
        chk("uio_out", uio_out, 8'h00);
        for (int i = 0; i < 4; i++) begin
            bus_cycle(NONE);
            chk("idle_uo", uo_out, 8'h01);
        end

        do_reset(8'h03);
        bus_cycle(ROM);
        chk("rom3_c1", uo_out, 8'h02);
        bus_cycle(NONE);
        chk("rom3_c2", uo_out, 8'h0A);
        bus_cycle(NONE);
        chk("rom3_c3", uo_out, 8'h12);
        bus_cycle(NONE);
        chk("rom3_c4", uo_out, 8'h19);
        bus_cycle(NONE);
        chk("rom3_c5", uo_out, 8'h19);

        do_reset(8'h01);
        bus_cycle(ROM);
        chk("b2b_c1", uo_out, 8'h02);
        bus_cycle(ROM);
        chk("b2b_c2", uo_out, 8'h09);
        bus_cycle(ROM);
        chk("b2b_c3", uo_out, 8'h09);
        bus_cycle(ROM);
        chk("b2b_c4", uo_out, 8'h0A);
        bus_cycle(ROM);
        chk("b2b_c5", uo_out, 8'h11);

        do_reset(8'h2A);
        bus_cycle(ROMIO);
        chk("conf_c1", uo_out, 8'h06);
        bus_cycle(NONE);
        chk("conf_c2", uo_out, 8'h0E);
        bus_cycle(NONE);
        chk("conf_c3", uo_out, 8'h15);
        bus_cycle(NONE);
        chk("conf_c4", uo_out, 8'h15);
        bus_cycle(NONE);
        chk("conf_sticky", uo_out[2], 1'b1);

        do_reset(8'h3F);
        for (int i = 0; i < 3; i++) begin
            bus_cycle(RAM);
            chk("ram0_uo", uo_out, 8'h01);
        end

        do_reset(8'h20);
        bus_cycle(IO);
        chk("io4_c1", uo_out, 8'h02);
        uio_in = 8'h08;
        bus_cycle(NONE);
        chk("io4_c2", uo_out, 8'h0A);
        bus_cycle(ROM);
        chk("io4_c3", uo_out, 8'h12);
        bus_cycle(NONE);
        chk("io4_c4", uo_out, 8'h1A);
        bus_cycle(NONE);
        chk("io4_c5", uo_out, 8'h21);

        do_reset(8'h01);
        for (int i = 0; i < 40; i++) begin
            bus_cycle(ROM);
            bus_cycle(NONE);
            bus_cycle(NONE);
            if (i == 30)
                chk("sat_31", uo_out, 8'hF9);
        end
        chk("sat_40", uo_out, 8'hF9);

        do_reset(8'h03);
        bus_cycle(ROM);
        bus_cycle(NONE);
        chk("mid_wait", uo_out, 8'h0A);
        rst_n = 1'b0;
        #1;
        chk("async_rst", uo_out, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_cycle(NONE);
        chk("post_rst", uo_out, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
